load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: DEPTH, 32, number of 64-bit doublewords in the attached data memory.
REQ-002 Ports; the block SHALL have one clock, and its reset SHALL be synchronous and active-low:
- CLK  in  1  clock; all state updates on the rising edge
- RST_N  in  1  synchronous active-low reset
- REQ_VALID  in  1  execute-stage request valid
- REQ_READY  out  1  block can accept a request
- REQ_WRITE  in  1  1 = store, 0 = load
- REQ_SIZE  in  2  00 byte, 01 half, 10 word, 11 doubleword
- REQ_SIGNED  in  1  sign-extend load result
- REQ_ADDR  in  64  byte address
- REQ_WDATA  in  64  store data, right-justified
- REQ_RD  in  5  load destination register
- MEM_READ  out  1  memory read strobe
- MEM_WRITE  out  1  memory write strobe
- MEM_ADDR  out  64  doubleword index, REQ_ADDR[63:3] zero-extended
- MEM_WR_DATA  out  64  merged doubleword to write
- MEM_RD_DATA  in  64  combinational memory read data
- RSP_VALID  out  1  load result valid
- RSP_READY  in  1  writeback stage accepts the result
- RSP_DATA  out  64  extended load result
- RSP_RD  out  5  destination register of RSP_DATA
- FAULT  out  1  one-cycle pulse for a rejected request

Function
REQ-003 States SHALL be IDLE, READ, WRITE and RESP; REQ_READY SHALL be 1 only in IDLE.
REQ-004 A request SHALL be accepted on an edge where REQ_VALID=1 and REQ_READY=1; on acceptance all request fields SHALL be latched.
REQ-005 Transitions from IDLE on acceptance SHALL be as follows. Load goes to READ. Doubleword store goes to WRITE. Sub-doubleword store goes to READ for read-modify-write.
REQ-006 In READ the block SHALL assert MEM_READ=1 for exactly one cycle and SHALL capture MEM_RD_DATA at the closing edge.
- Load: goes to RESP.
- Store: goes to WRITE.
REQ-007 In WRITE the block SHALL assert MEM_WRITE=1 for exactly one cycle with the merged data, then go to IDLE; stores SHALL produce no response.
REQ-008 In RESP, RSP_VALID=1 and RSP_DATA/RSP_RD SHALL be held stable until the edge where RSP_READY=1, then the block goes to IDLE.
REQ-009 Latency, with acceptance at edge N:
- Load: RSP_VALID=1 in cycle N+2 at the earliest.
- Doubleword store: REQ_READY=1 again in N+2.
- Sub-doubleword store: REQ_READY=1 again in N+3.
REQ-010 Byte lanes SHALL be little-endian, with the lane starting at bit 8*REQ_ADDR[2:0].
- Load: extracts 8/16/32/64 bits from that lane, then zero-extends, or sign-extends when REQ_SIGNED=1.
- Store: replaces only that lane of the captured doubleword with the low bits of REQ_WDATA.
REQ-011 MEM_READ and MEM_WRITE SHALL be 0 in every state other than READ and WRITE respectively; MEM_ADDR and MEM_WR_DATA SHALL be 0 when no strobe is asserted.
REQ-012 A request whose doubleword index is >= DEPTH SHALL be accepted and SHALL NOT access memory. FAULT SHALL pulse in the cycle after acceptance, and the block SHALL stay in IDLE.
REQ-013 RSP_READY asserted outside RESP SHALL have no effect; REQ_VALID while busy SHALL be ignored, not queued.

Reset
REQ-014 At an edge with RST_N=0 the state SHALL become IDLE and all latched fields and RSP_DATA/RSP_RD SHALL become 0.
REQ-015 While RST_N=0, every output SHALL read 0, including REQ_READY, MEM_READ, MEM_WRITE, RSP_VALID and FAULT.
REQ-016 Reset asserted in any state SHALL abandon the operation. No memory write SHALL occur at a reset edge, even from WRITE, and no response SHALL be produced afterward.

Configuration
REQ-017 The macro LSU_MISALIGN_CHECK_EN SHALL control alignment checking.
- Defined: a request with REQ_ADDR not aligned to its size SHALL be handled exactly as in REQ-012 (FAULT pulse, no access).
- Undefined: the low log2(size) address bits SHALL be forced to 0 before use, and misalignment SHALL never raise FAULT.

Verification
REQ-018 Doubleword store, then doubleword load:
- Store addr 0x10, data 0x1122334455667788 -> MEM_WRITE in N+1 with MEM_ADDR=2.
- Load addr 0x10 -> RSP_DATA=0x1122334455667788, RSP_VALID in N+2.
REQ-019 Byte store, addr 0x13, data 0xAB, over 0x1122334455667788 -> READ then WRITE cycle; memory word becomes 0x11223344AB667788.
REQ-020 Signed word load, addr 0x14, from 0x80000000_00000000:
- REQ_SIGNED=1 -> RSP_DATA=0xFFFFFFFF80000000.
- REQ_SIGNED=0 -> RSP_DATA=0x0000000080000000.
REQ-021 Backpressure: load response with RSP_READY=0 for 3 cycles -> RSP_VALID and RSP_DATA held stable and REQ_READY=0 throughout; state is IDLE one edge after RSP_READY=1.
REQ-022 Faults:
- Load addr 0x100 with DEPTH=32 -> FAULT pulse, no MEM_READ.
- Half load addr 0x11 with LSU_MISALIGN_CHECK_EN -> FAULT pulse.
- Same half load without the macro -> data read from offset 0x10.
REQ-023 Reset during WRITE: RST_N=0 in the WRITE cycle of a store to 0x08 -> memory location unchanged, all outputs 0, REQ_READY=1 one cycle after reset release.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit. It accepts one execute-stage request at a time and talks to
// a doubleword-wide memory whose read data is combinational. Sub-doubleword
// stores use read-modify-write. Loads return a zero- or sign-extended lane.
// Optional feature macro: LSU_MISALIGN_CHECK_EN. When it is defined, a
// misaligned request faults. Otherwise the low address bits are forced to zero.
module load_store_unit #(
    parameter int DEPTH = 32
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WRITE,
    input  logic [1:0]  REQ_SIZE,
    input  logic        REQ_SIGNED,
    input  logic [63:0] REQ_ADDR,
    input  logic [63:0] REQ_WDATA,
    input  logic [4:0]  REQ_RD,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [63:0] MEM_ADDR,
    output logic [63:0] MEM_WR_DATA,
    input  logic [63:0] MEM_RD_DATA,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [63:0] RSP_DATA,
    output logic [4:0]  RSP_RD,
    output logic        FAULT
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state, state_next;
    logic        write_q, signed_q, fault_q;
    logic [1:0]  size_q;
    logic [63:0] addr_q, wdata_q, rsp_data_q;
    logic [4:0]  rd_q;

    logic [2:0]  align_mask;
    logic [63:0] req_addr_eff;
    logic        req_bad, accept;
    logic [5:0]  lane_shift;
    logic [63:0] lane_mask, lane_data, merged;

    // Bit mask that covers the low bits of a value of the given access size.
    function automatic logic [63:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   size_mask = 64'h0000_0000_0000_00FF;
            2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    // Zero- or sign-extends a right-justified lane to 64 bits.
    function automatic logic [63:0] extend(input logic [63:0] d, input logic [1:0] size,
                                           input logic sgn);
        case (size)
            2'b00:   extend = {{56{sgn & d[7]}},  d[7:0]};
            2'b01:   extend = {{48{sgn & d[15]}}, d[15:0]};
            2'b10:   extend = {{32{sgn & d[31]}}, d[31:0]};
            default: extend = d;
        endcase
    endfunction

    // Decode the incoming request: address alignment and range check.
    always_comb begin
        case (REQ_SIZE)
            2'b00:   align_mask = 3'b000;
            2'b01:   align_mask = 3'b001;
            2'b10:   align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
`ifdef LSU_MISALIGN_CHECK_EN
        req_addr_eff = REQ_ADDR;
        req_bad      = (REQ_ADDR[63:3] >= 61'(DEPTH)) || (|(REQ_ADDR[2:0] & align_mask));
`else
        req_addr_eff = {REQ_ADDR[63:3], REQ_ADDR[2:0] & ~align_mask};
        req_bad      = (REQ_ADDR[63:3] >= 61'(DEPTH));
`endif
        accept = REQ_VALID && (state == IDLE);
    end

    // Lane extraction for loads and lane merging for stores, both based on the
    // captured doubleword.
    always_comb begin
        lane_shift = {addr_q[2:0], 3'b000};
        lane_mask  = size_mask(size_q);
        lane_data  = MEM_RD_DATA >> lane_shift;
        merged     = (MEM_RD_DATA & ~(lane_mask << lane_shift))
                   | ((wdata_q & lane_mask) << lane_shift);
    end

    // State register.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!RST_N) state <= IDLE;
        else        state <= state_next;
    end

    // Request fields, the merged store data, the load result and the fault pulse.
    always_ff @(posedge CLK) begin
        // NOTE: every latched field is cleared on reset so nothing stale survives an abandoned operation.
        if (!RST_N) begin
            write_q    <= 1'b0;
            signed_q   <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            rsp_data_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            fault_q <= accept && req_bad;
            if (accept) begin
                write_q  <= REQ_WRITE;
                signed_q <= REQ_SIGNED;
                size_q   <= REQ_SIZE;
                addr_q   <= req_addr_eff;
                wdata_q  <= REQ_WDATA;
                rd_q     <= REQ_RD;
            end else if (state == READ) begin
                if (write_q) wdata_q    <= merged;
                else         rsp_data_q <= extend(lane_data, size_q, signed_q);
            end
        end
    end

    // Next-state logic and outputs. Every output is forced low while reset is held.
    always_comb begin
        state_next  = state;
        REQ_READY   = 1'b0;
        MEM_READ    = 1'b0;
        MEM_WRITE   = 1'b0;
        MEM_ADDR    = '0;
        MEM_WR_DATA = '0;
        RSP_VALID   = 1'b0;
        RSP_DATA    = '0;
        RSP_RD      = '0;
        FAULT       = 1'b0;
        case (state)
            IDLE: begin
                REQ_READY = 1'b1;
                if (accept && !req_bad) begin
                    if (!REQ_WRITE || REQ_SIZE != 2'b11) state_next = READ;
                    else                                 state_next = WRITE;
                end
            end
            READ: begin
                MEM_READ   = 1'b1;
                MEM_ADDR   = {3'b000, addr_q[63:3]};
                state_next = write_q ? WRITE : RESP;
            end
            WRITE: begin
                MEM_WRITE   = 1'b1;
                MEM_ADDR    = {3'b000, addr_q[63:3]};
                MEM_WR_DATA = wdata_q;
                state_next  = IDLE;
            end
            RESP: begin
                RSP_VALID = 1'b1;
                if (RSP_READY) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (RST_N) begin
            RSP_DATA = rsp_data_q;
            RSP_RD   = rd_q;
            FAULT    = fault_q;
        end else begin
            REQ_READY   = 1'b0;
            MEM_READ    = 1'b0;
            MEM_WRITE   = 1'b0;
            MEM_ADDR    = '0;
            MEM_WR_DATA = '0;
            RSP_VALID   = 1'b0;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 32-doubleword memory model.
// The bench covers stores, loads, read-modify-write, backpressure, faults and
// reset during WRITE.
module tb_load_store_unit;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        REQ_VALID, REQ_READY, REQ_WRITE, REQ_SIGNED;
    logic [1:0]  REQ_SIZE;
    logic [63:0] REQ_ADDR, REQ_WDATA;
    logic [4:0]  REQ_RD;
    logic        MEM_READ, MEM_WRITE;
    logic [63:0] MEM_ADDR, MEM_WR_DATA, MEM_RD_DATA;
    logic        RSP_VALID, RSP_READY, FAULT;
    logic [63:0] RSP_DATA;
    logic [4:0]  RSP_RD;

    logic [63:0] mem [0:31] = '{default: 64'h0};
    int errors = 0;
    int checks = 0;

    load_store_unit #(.DEPTH(32)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
        .REQ_SIZE(REQ_SIZE), .REQ_SIGNED(REQ_SIGNED), .REQ_ADDR(REQ_ADDR),
        .REQ_WDATA(REQ_WDATA), .REQ_RD(REQ_RD),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR),
        .MEM_WR_DATA(MEM_WR_DATA), .MEM_RD_DATA(MEM_RD_DATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
        .RSP_RD(RSP_RD), .FAULT(FAULT)
    );

    always #5 CLK = ~CLK;

    // Memory model: combinational read and write on the rising edge.
    assign MEM_RD_DATA = (MEM_ADDR < 64'd32) ? mem[MEM_ADDR[4:0]] : 64'h0;
    always @(posedge CLK) begin
        if (MEM_WRITE && MEM_ADDR < 64'd32) mem[MEM_ADDR[4:0]] <= MEM_WR_DATA;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock cycle. Outputs are then sampled at the falling edge.
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drive(input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd);
        REQ_VALID  = 1'b1;
        REQ_WRITE  = wr;
        REQ_SIZE   = size;
        REQ_SIGNED = sgn;
        REQ_ADDR   = addr;
        REQ_WDATA  = wdata;
        REQ_RD     = rd;
    endtask

    initial begin
        RST_N = 1'b0; RSP_READY = 1'b0;
        REQ_VALID = 1'b0; REQ_WRITE = 1'b0; REQ_SIZE = 2'b00; REQ_SIGNED = 1'b0;
        REQ_ADDR = '0; REQ_WDATA = '0; REQ_RD = '0;
        @(negedge CLK);
        step();
        check("rst_req_ready", REQ_READY, 0);
        check("rst_mem_read",  MEM_READ, 0);
        check("rst_rsp_valid", RSP_VALID, 0);
        check("rst_fault",     FAULT, 0);
        RST_N = 1'b1;
        step();
        check("idle_req_ready", REQ_READY, 1);

        // Doubleword store to 0x10.
        drive(1, 2'b11, 0, 64'h10, 64'h1122334455667788, 5'd0);
        step(); REQ_VALID = 1'b0;
        check("sd_mem_write", MEM_WRITE, 1);
        check("sd_mem_addr",  MEM_ADDR, 64'd2);
        check("sd_wr_data",   MEM_WR_DATA, 64'h1122334455667788);
        check("sd_mem_read",  MEM_READ, 0);
        step();
        check("sd_ready_n2",  REQ_READY, 1);
        check("sd_addr_idle", MEM_ADDR, 0);
        check("sd_mem",       mem[2], 64'h1122334455667788);

        // Doubleword load from 0x10.
        drive(0, 2'b11, 0, 64'h10, 64'h0, 5'd7);
        RSP_READY = 1'b1;
        step(); REQ_VALID = 1'b0;
        check("ld_mem_read",   MEM_READ, 1);
        check("ld_rsp_early",  RSP_VALID, 0);
        step();
        check("ld_rsp_valid",  RSP_VALID, 1);
        check("ld_rsp_data",   RSP_DATA, 64'h1122334455667788);
        check("ld_rsp_rd",     RSP_RD, 64'd7);
        step();
        check("ld_back_idle",  REQ_READY, 1);
        check("ld_rsp_clear",  RSP_VALID, 0);

        // Byte store to 0x13: read-modify-write.
        drive(1, 2'b00, 0, 64'h13, 64'hAB, 5'd0);
        step(); REQ_VALID = 1'b0;
        check("sb_mem_read",   MEM_READ, 1);
        check("sb_no_write",   MEM_WRITE, 0);
        step();
        check("sb_mem_write",  MEM_WRITE, 1);
        check("sb_wr_data",    MEM_WR_DATA, 64'h11223344AB667788);
        step();
        check("sb_ready_n3",   REQ_READY, 1);
        check("sb_mem",        mem[2], 64'h11223344AB667788);

        // Backpressure on a load; a request issued while busy must be ignored.
        RSP_READY = 1'b0;
        drive(0, 2'b11, 0, 64'h10, 64'h0, 5'd3);
        step();
        drive(1, 2'b11, 0, 64'h18, 64'hDEAD, 5'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            check("bp_rsp_valid", RSP_VALID, 1);
            check("bp_rsp_data",  RSP_DATA, 64'h11223344AB667788);
            check("bp_req_ready", REQ_READY, 0);
            step();
        end
        REQ_VALID = 1'b0;
        check("bp_still_held", RSP_VALID, 1);
        RSP_READY = 1'b1;
        step();
        check("bp_idle",       REQ_READY, 1);
        check("bp_rsp_done",   RSP_VALID, 0);
        step();
        check("bp_no_queue",   MEM_WRITE, 0);
        check("bp_mem3",       mem[3], 0);

        // Out-of-range load.
        drive(0, 2'b11, 0, 64'h100, 64'h0, 5'd1);
        step(); REQ_VALID = 1'b0;
        check("oor_fault",     FAULT, 1);
        check("oor_no_read",   MEM_READ, 0);
        check("oor_idle",      REQ_READY, 1);
        step();
        check("oor_pulse_end", FAULT, 0);

        // Misaligned half load from 0x11.
        drive(0, 2'b01, 0, 64'h11, 64'h0, 5'd2);
        step(); REQ_VALID = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        check("mis_fault",     FAULT, 1);
        check("mis_no_read",   MEM_READ, 0);
        step();
`else
        check("mis_no_fault",  FAULT, 0);
        step();
        check("mis_rsp_valid", RSP_VALID, 1);
        check("mis_rsp_data",  RSP_DATA, 64'h7788);
        step();
`endif
        check("mis_idle",      REQ_READY, 1);

        // Signed and unsigned word loads from 0x14.
        drive(1, 2'b11, 0, 64'h10, 64'h8000000000000000, 5'd0);
        step(); REQ_VALID = 1'b0;
        step();
        drive(0, 2'b10, 1, 64'h14, 64'h0, 5'd4);
        step(); REQ_VALID = 1'b0;
        step();
        check("lw_signed",     RSP_DATA, 64'hFFFFFFFF80000000);
        step();
        drive(0, 2'b10, 0, 64'h14, 64'h0, 5'd4);
        step(); REQ_VALID = 1'b0;
        step();
        check("lw_unsigned",   RSP_DATA, 64'h0000000080000000);
        step();

        // Reset during WRITE of a store to 0x08.
        drive(1, 2'b11, 0, 64'h08, 64'hCAFE, 5'd0);
        step(); REQ_VALID = 1'b0;
        step();
        check("rw_pre_mem",    mem[1], 64'hCAFE);
        drive(1, 2'b11, 0, 64'h08, 64'h5555, 5'd0);
        step(); REQ_VALID = 1'b0;
        check("rw_in_write",   MEM_WRITE, 1);
        RST_N = 1'b0;
        #1;
        check("rw_mem_write0", MEM_WRITE, 0);
        check("rw_addr0",      MEM_ADDR, 0);
        check("rw_wdata0",     MEM_WR_DATA, 0);
        check("rw_ready0",     REQ_READY, 0);
        check("rw_rspdata0",   RSP_DATA, 0);
        step();
        check("rw_mem_kept",   mem[1], 64'hCAFE);
        RST_N = 1'b1;
        step();
        check("rw_ready_after", REQ_READY, 1);
        check("rw_no_rsp",     RSP_VALID, 0);
        check("rw_rsp_data",   RSP_DATA, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
